regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the pipelined RISC-V core.
- Successor of the single-write, two-read file: configurable width, depth, read and write port counts, and optional hardwired zero register.
- Adds same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a valid/ready debug dump engine that streams all registers.

Parameters:
DW, 32, data width in bits
DEPTH, 32, number of registers (power of two, >=2)
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-high
rd_addr_i  in  NUM_RD*AW  read addresses, port k at [k*AW +: AW]
rd_data_o  out  NUM_RD*DW  read data, combinational
rd_busy_o  out  NUM_RD  read operand has a pending producer
wr_en_i  in  NUM_WR  write enables
wr_addr_i  in  NUM_WR*AW  write addresses
wr_data_i  in  NUM_WR*DW  write data
iss_en_i  in  1  instruction issue with destination register
iss_addr_i  in  AW  destination register to mark busy
dump_start_i  in  1  request a full register dump
dump_valid_o  out  1  dump beat valid
dump_ready_i  in  1  dump beat accepted
dump_idx_o  out  AW  register index of current beat
dump_data_o  out  DW  register value of current beat
dump_active_o  out  1  dump engine not idle
dump_done_o  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (rst_n=1, asynchronous): all registers 0; all busy bits 0; dump FSM IDLE. dump_valid_o, dump_active_o, dump_done_o, dump_idx_o, and dump_data_o are all 0.
- Write: on the rising edge, each wr_en_i[j] writes wr_data_i[j] to wr_addr_i[j]. If both write ports target the same address, the higher port index wins. With ZERO_REG=1, writes to address 0 are dropped.
- Read (combinational, zero latency):
  - Address 0 with ZERO_REG=1 returns 0.
  - Otherwise, if any enabled write port targets the same address in the current cycle, return that write data (highest index wins).
  - Otherwise return the stored value.
- Scoreboard:
  - iss_en_i sets busy[iss_addr_i] at the edge.
  - Any enabled write to an address clears its busy bit at the edge.
  - Set and clear on the same address in the same cycle: set wins, because a new producer has issued.
  - Address 0 with ZERO_REG=1 is never set.
- rd_busy_o[k] = busy[rd_addr_i[k]] AND NOT (any enabled write to rd_addr_i[k] this cycle). A bypassed operand is not busy.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE -> SEND on dump_start_i; index is set to 0.
  - SEND: dump_valid_o=1, dump_idx_o=index, dump_data_o = bypassed read of index. A beat is accepted when valid && ready; the index then increments. Acceptance at index DEPTH-1 moves to DONE.
  - dump_valid_o and dump_idx_o are held stable until accepted. dump_data_o reflects live contents, including writes landing on the current index.
  - DONE: dump_done_o=1 for exactly one cycle, then IDLE.
  - dump_start_i outside IDLE is ignored.
  - dump_active_o=1 in SEND and DONE.
- Reset mid-dump: FSM returns to IDLE immediately, with no done pulse.
- Register writes and scoreboard updates continue during a dump and are never stalled by it.

Decomposition:
- Package regfile_pkg holds dump_state_e (IDLE/SEND/DONE) and localparams for default DW/DEPTH.
- One sub-module, regfile_dump_fsm: owns the index counter and valid/ready/done logic, and reads data through an index/data lookup port on the core array.

Test Plan:
- Reset: assert rst_n=1 mid-simulation -> every read returns 0, rd_busy_o=0, dump outputs 0, regardless of prior contents.
- Bypass and zero register:
  - Write 0xDEADBEEF to r5 while reading r5 on port 0 in the same cycle -> rd_data_o=0xDEADBEEF that cycle and after.
  - Write 0x1234 to r0 -> reads 0.
- Write priority (NUM_WR=2): both ports write r7, with 0x11 on port 0 and 0x22 on port 1 -> r7=0x22, and the same-cycle bypass also shows 0x22.
- Scoreboard:
  - Issue r3 -> next cycle rd_busy_o=1 for r3 reads.
  - Write r3 and issue r3 in the same cycle -> busy stays 1.
  - Write r3 alone -> rd_busy_o=0 during the write cycle and after.
- Dump with backpressure:
  - Preload r1=1..r31=31 and start a dump; hold ready low for 3 cycles on beat 4 -> idx/data stable at 4/4 throughout.
  - 32 beats idx 0..31 in order, then a single dump_done_o pulse.
- Reset mid-dump: assert rst_n=1 at beat 10 -> dump_valid_o=0 and IDLE immediately, no done pulse; a fresh dump_start_i restarts at idx 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the multi-port register file
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_e;
  localparam int DEF_DW = 32;
  localparam int DEF_DEPTH = 32;
endpackage

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: read, write, issue and dump signals of the register file
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  localparam int AW = $clog2(DEPTH);
  logic [NUM_RD*AW-1:0] rd_addr_i;
  logic [NUM_RD*DW-1:0] rd_data_o;
  logic [NUM_RD-1:0] rd_busy_o;
  logic [NUM_WR-1:0] wr_en_i;
  logic [NUM_WR*AW-1:0] wr_addr_i;
  logic [NUM_WR*DW-1:0] wr_data_i;
  logic iss_en_i;
  logic [AW-1:0] iss_addr_i;
  logic dump_start_i;
  logic dump_valid_o;
  logic dump_ready_i;
  logic [AW-1:0] dump_idx_o;
  logic [DW-1:0] dump_data_o;
  logic dump_active_o;
  logic dump_done_o;
  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i, dump_start_i, dump_ready_i,
    input rd_data_o, rd_busy_o, dump_valid_o, dump_idx_o, dump_data_o, dump_active_o, dump_done_o
  );
  modport slave (
    input rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, iss_en_i, iss_addr_i, dump_start_i, dump_ready_i,
    output rd_data_o, rd_busy_o, dump_valid_o, dump_idx_o, dump_data_o, dump_active_o, dump_done_o
  );
endinterface

// File: rtl/regfile_dump_fsm.sv
// regfile_dump_fsm: streams every register index/value as valid/ready beats
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ready,
  input  logic [DW-1:0] look_data,
  output logic [AW-1:0] look_idx,
  output logic          valid,
  output logic [AW-1:0] idx,
  output logic [DW-1:0] data,
  output logic          active,
  output logic          done
);
  dump_state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  // state and beat index registers; reset drops any dump in flight without a done pulse
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
    end
  end
  // next state: start only honoured in IDLE, advance on each accepted beat, done lasts one cycle
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    if (state_q == IDLE && start) begin
      state_d = SEND;
      idx_d = '0;
    end else if (state_q == SEND && ready) begin
      idx_d = idx_q + 1'b1;
      state_d = (idx_q == AW'(DEPTH - 1)) ? DONE : SEND;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    valid = state_q == SEND;
    look_idx = idx_q;
    idx = valid ? idx_q : '0;
    data = valid ? look_data : '0;
    active = state_q != IDLE;
    done = state_q == DONE;
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write bypass, busy scoreboard and dump engine
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int ZERO_REG = 1
) (
  input logic clk,
  input logic rst_n,
  regfile_mp_sb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [AW-1:0] la [NUM_RD+1];
  logic [DW-1:0] ld [NUM_RD+1];
  logic lh [NUM_RD+1];
  logic [AW-1:0] dump_idx;
  // storage: higher write port lands last so it wins on a shared address; r0 stays 0 when hardwired
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (bus.wr_en_i[j] && !(ZERO_REG != 0 && bus.wr_addr_i[j*AW +: AW] == '0))
          mem[bus.wr_addr_i[j*AW +: AW]] <= bus.wr_data_i[j*DW +: DW];
    end
  end
  // scoreboard: writes retire producers, an issue on the same address re-marks it busy
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (bus.wr_en_i[j]) busy[bus.wr_addr_i[j*AW +: AW]] <= 1'b0;
      if (bus.iss_en_i && !(ZERO_REG != 0 && bus.iss_addr_i == '0)) busy[bus.iss_addr_i] <= 1'b1;
    end
  end
  // bypassed lookups for every read port plus the dump engine's port in the last slot
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) la[k] = bus.rd_addr_i[k*AW +: AW];
    la[NUM_RD] = dump_idx;
    for (int k = 0; k <= NUM_RD; k++) begin
      lh[k] = 1'b0;
      ld[k] = mem[la[k]];
      for (int j = 0; j < NUM_WR; j++)
        if (bus.wr_en_i[j] && bus.wr_addr_i[j*AW +: AW] == la[k]) begin
          lh[k] = 1'b1;
          ld[k] = bus.wr_data_i[j*DW +: DW];
        end
      if (ZERO_REG != 0 && la[k] == '0) ld[k] = '0;
    end
  end
  // read outputs: a bypassed operand is already available so it is never reported busy
  always_comb begin
    bus.rd_data_o = '0;
    bus.rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_data_o[k*DW +: DW] = ld[k];
      bus.rd_busy_o[k] = busy[la[k]] & ~lh[k];
    end
  end
  regfile_dump_fsm #(.DW(DW), .DEPTH(DEPTH)) u_dump (
    .clk(clk),
    .rst_n(rst_n),
    .start(bus.dump_start_i),
    .ready(bus.dump_ready_i),
    .look_data(ld[NUM_RD]),
    .look_idx(dump_idx),
    .valid(bus.dump_valid_o),
    .idx(bus.dump_idx_o),
    .data(bus.dump_data_o),
    .active(bus.dump_active_o),
    .done(bus.dump_done_o)
  );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed checks of bypass, zero register, priority, scoreboard and dump
module tb_regfile_mp_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  regfile_mp_sb_if #(.DW(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus ();
  regfile_mp_sb #(.DW(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
    bus.wr_en_i[p] = en;
    bus.wr_addr_i[p*5 +: 5] = a;
    bus.wr_data_i[p*32 +: 32] = d;
  endtask
  task automatic rd(input int p, input logic [4:0] a);
    bus.rd_addr_i[p*5 +: 5] = a;
  endtask
  initial begin
    bus.rd_addr_i = '0;
    bus.wr_en_i = '0;
    bus.wr_addr_i = '0;
    bus.wr_data_i = '0;
    bus.iss_en_i = 1'b0;
    bus.iss_addr_i = '0;
    bus.dump_start_i = 1'b0;
    bus.dump_ready_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_rd0", bus.rd_data_o[31:0], 0);
    chk("rst_busy", bus.rd_busy_o, 0);
    chk("rst_valid", bus.dump_valid_o, 0);
    chk("rst_active", bus.dump_active_o, 0);
    chk("rst_done", bus.dump_done_o, 0);
    chk("rst_idx", bus.dump_idx_o, 0);
    chk("rst_ddata", bus.dump_data_o, 0);
    wr(0, 1, 5, 32'hDEADBEEF);
    rd(0, 5);
    #1;
    chk("byp_r5", bus.rd_data_o[31:0], 32'hDEADBEEF);
    tick();
    wr(0, 0, 0, 0);
    #1;
    chk("stored_r5", bus.rd_data_o[31:0], 32'hDEADBEEF);
    wr(0, 1, 0, 32'h1234);
    rd(0, 0);
    #1;
    chk("zero_byp", bus.rd_data_o[31:0], 0);
    tick();
    wr(0, 0, 0, 0);
    #1;
    chk("zero_stored", bus.rd_data_o[31:0], 0);
    wr(0, 1, 7, 32'h11);
    wr(1, 1, 7, 32'h22);
    rd(1, 7);
    #1;
    chk("prio_byp", bus.rd_data_o[63:32], 32'h22);
    tick();
    wr(0, 0, 0, 0);
    wr(1, 0, 0, 0);
    #1;
    chk("prio_stored", bus.rd_data_o[63:32], 32'h22);
    bus.iss_en_i = 1'b1;
    bus.iss_addr_i = 5'd3;
    rd(0, 3);
    #1;
    chk("iss_before", bus.rd_busy_o[0], 0);
    tick();
    bus.iss_en_i = 1'b0;
    #1;
    chk("iss_busy", bus.rd_busy_o[0], 1);
    wr(0, 1, 3, 32'h33);
    bus.iss_en_i = 1'b1;
    #1;
    chk("wr_iss_byp_busy", bus.rd_busy_o[0], 0);
    tick();
    wr(0, 0, 0, 0);
    bus.iss_en_i = 1'b0;
    #1;
    chk("wr_iss_busy", bus.rd_busy_o[0], 1);
    wr(0, 1, 3, 32'h44);
    #1;
    chk("wr_clr_during", bus.rd_busy_o[0], 0);
    chk("wr_clr_data", bus.rd_data_o[31:0], 32'h44);
    tick();
    wr(0, 0, 0, 0);
    #1;
    chk("wr_clr_after", bus.rd_busy_o[0], 0);
    bus.iss_en_i = 1'b1;
    bus.iss_addr_i = 5'd0;
    tick();
    bus.iss_addr_i = 5'd9;
    tick();
    bus.iss_en_i = 1'b0;
    rd(0, 0);
    rd(1, 9);
    #1;
    chk("r0_never_busy", bus.rd_busy_o[0], 0);
    chk("r9_busy", bus.rd_busy_o[1], 1);
    rd(0, 5);
    rd(1, 7);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_r5", bus.rd_data_o[31:0], 0);
    chk("mid_rst_r7", bus.rd_data_o[63:32], 0);
    rd(1, 9);
    #1;
    chk("mid_rst_busy", bus.rd_busy_o, 0);
    tick();
    rst_n = 1'b0;
    for (int i = 1; i < 32; i++) begin
      wr(0, 1, 5'(i), 32'(i));
      tick();
    end
    wr(0, 0, 0, 0);
    bus.dump_start_i = 1'b1;
    tick();
    bus.dump_start_i = 1'b0;
    for (int b = 0; b < 32; b++) begin
      if (b == 4)
        for (int s = 0; s < 3; s++) begin
          bus.dump_ready_i = 1'b0;
          tick();
          chk("stall_valid", bus.dump_valid_o, 1);
          chk("stall_idx", bus.dump_idx_o, 4);
          chk("stall_data", bus.dump_data_o, 4);
        end
      if (b == 6) bus.dump_start_i = 1'b1;
      chk("beat_valid", bus.dump_valid_o, 1);
      chk("beat_idx", bus.dump_idx_o, 64'(b));
      chk("beat_data", bus.dump_data_o, 64'(b));
      chk("beat_nodone", bus.dump_done_o, 0);
      bus.dump_ready_i = 1'b1;
      tick();
      bus.dump_ready_i = 1'b0;
      bus.dump_start_i = 1'b0;
    end
    chk("done_pulse", bus.dump_done_o, 1);
    chk("done_active", bus.dump_active_o, 1);
    chk("done_novalid", bus.dump_valid_o, 0);
    tick();
    chk("done_once", bus.dump_done_o, 0);
    chk("idle_inactive", bus.dump_active_o, 0);
    bus.dump_start_i = 1'b1;
    tick();
    bus.dump_start_i = 1'b0;
    bus.dump_ready_i = 1'b1;
    for (int b = 0; b < 10; b++) tick();
    bus.dump_ready_i = 1'b0;
    chk("pre_rst_idx", bus.dump_idx_o, 10);
    chk("pre_rst_data", bus.dump_data_o, 10);
    rst_n = 1'b1;
    #1;
    chk("rst_dump_valid", bus.dump_valid_o, 0);
    chk("rst_dump_active", bus.dump_active_o, 0);
    chk("rst_dump_idx", bus.dump_idx_o, 0);
    tick();
    chk("rst_dump_nodone", bus.dump_done_o, 0);
    rst_n = 1'b0;
    tick();
    chk("rst_dump_nodone2", bus.dump_done_o, 0);
    bus.dump_start_i = 1'b1;
    tick();
    bus.dump_start_i = 1'b0;
    chk("restart_valid", bus.dump_valid_o, 1);
    chk("restart_idx", bus.dump_idx_o, 0);
    chk("restart_active", bus.dump_active_o, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
